// File: rtl/kernel_cra_slave_pkg.sv
// Shared definitions for the kernel CRA responder: register map, status bit
// positions, FSM state encoding and the byte-enable merge helper.
package kernel_cra_pkg;

  localparam int CRA_DATA_W = 64;
  localparam int CRA_BE_W   = CRA_DATA_W / 8;

  localparam int ADDR_CTRL   = 0;
  localparam int ADDR_CYCLES = 1;
  localparam int ADDR_RUNS   = 2;

  localparam int BIT_START   = 0;
  localparam int BIT_BUSY    = 1;
  localparam int BIT_DONE    = 2;
  localparam int BIT_IRQ_EN  = 3;
  localparam int BIT_ARG_ERR = 4;

  localparam int RUNS_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Byte b of the result comes from new_word when be[b] is set, else from old_word.
  function automatic logic [CRA_DATA_W-1:0] be_merge(
    input logic [CRA_DATA_W-1:0] old_word,
    input logic [CRA_DATA_W-1:0] new_word,
    input logic [CRA_BE_W-1:0]   be
  );
    logic [CRA_DATA_W-1:0] merged;
    merged = old_word;
    for (int b = 0; b < CRA_BE_W; b++) begin
      if (be[b]) begin
        merged[b*8 +: 8] = new_word[b*8 +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/kernel_cra_slave_if.sv
// Avalon-MM CRA bus bundle; the host/bench side uses the master modport, the
// register file uses the slave modport.
interface kernel_cra_slave_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64
) ();

  logic                  cra_read;
  logic                  cra_write;
  logic [ADDR_W-1:0]     cra_address;
  logic [DATA_W-1:0]     cra_writedata;
  logic [DATA_W/8-1:0]   cra_byteenable;
  logic [DATA_W-1:0]     cra_readdata;
  logic                  cra_readdatavalid;
  logic                  cra_waitrequest;

  modport master (
    output cra_read,
    output cra_write,
    output cra_address,
    output cra_writedata,
    output cra_byteenable,
    input  cra_readdata,
    input  cra_readdatavalid,
    input  cra_waitrequest
  );

  modport slave (
    input  cra_read,
    input  cra_write,
    input  cra_address,
    input  cra_writedata,
    input  cra_byteenable,
    output cra_readdata,
    output cra_readdatavalid,
    output cra_waitrequest
  );

endinterface

// File: rtl/kernel_cra_slave.sv
// CRA register file for one kernel: argument words, start/busy/done control FSM,
// run-cycle and run-count counters, level interrupt and a fixed-latency read port.
module kernel_cra_slave
  import kernel_cra_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = CRA_DATA_W,
  parameter int ARG_BASE  = 5,
  parameter int ARG_WORDS = 11
) (
  input  logic                        clk,
  input  logic                        rst,
  kernel_cra_slave_if.slave           cra,
  output logic                        kernel_start,
  output logic [DATA_W*ARG_WORDS-1:0] kernel_args,
  input  logic                        kernel_done,
  output logic                        kernel_irq
);

  state_t              state_q;
  logic                start_q;
  logic                irq_en_q;
  logic                arg_err_q;
  logic [DATA_W-1:0]   cycles_q;
  logic [RUNS_W-1:0]   runs_q;
  logic [DATA_W-1:0]   args_q [ARG_WORDS];
  logic                rvalid_q;
  logic [DATA_W-1:0]   rdata_q;

  logic                busy;
  logic                ctrl_wr;
  logic                start_req;
  logic                done_clr;
  logic                err_clr;
  logic                arg_hit;
  logic                arg_err_set;
  logic [DATA_W-1:0]   ctrl_status;
  logic [DATA_W-1:0]   rd_mux_d;

  assign busy = (state_q == RUN);

  // Control bits live in byte 0, so a CTRL write without byteenable[0] is a no-op.
  always_comb begin
    ctrl_wr   = cra.cra_write && (cra.cra_address == ADDR_W'(ADDR_CTRL)) && cra.cra_byteenable[0];
    start_req = ctrl_wr && cra.cra_writedata[BIT_START];
    done_clr  = ctrl_wr && cra.cra_writedata[BIT_DONE];
    err_clr   = ctrl_wr && cra.cra_writedata[BIT_ARG_ERR];
    arg_hit   = 1'b0;
    for (int k = 0; k < ARG_WORDS; k++) begin
      if (cra.cra_address == ADDR_W'(ARG_BASE + k)) begin
        arg_hit = cra.cra_write;
      end
    end
    arg_err_set = busy && (start_req || arg_hit);
  end

  always_comb begin
    ctrl_status              = '0;
    ctrl_status[BIT_BUSY]    = busy;
    ctrl_status[BIT_DONE]    = (state_q == DONE);
    ctrl_status[BIT_IRQ_EN]  = irq_en_q;
    ctrl_status[BIT_ARG_ERR] = arg_err_q;
  end

  // Reads see register contents before any write landing in the same cycle.
  always_comb begin
    rd_mux_d = '0;
    if (cra.cra_address == ADDR_W'(ADDR_CTRL)) begin
      rd_mux_d = ctrl_status;
    end else if (cra.cra_address == ADDR_W'(ADDR_CYCLES)) begin
      rd_mux_d = cycles_q;
    end else if (cra.cra_address == ADDR_W'(ADDR_RUNS)) begin
      rd_mux_d = {{(DATA_W-RUNS_W){1'b0}}, runs_q};
    end
    for (int k = 0; k < ARG_WORDS; k++) begin
      if (cra.cra_address == ADDR_W'(ARG_BASE + k)) begin
        rd_mux_d = args_q[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      irq_en_q  <= 1'b0;
      arg_err_q <= 1'b0;
      cycles_q  <= '0;
      runs_q    <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      for (int k = 0; k < ARG_WORDS; k++) begin
        args_q[k] <= '0;
      end
    end else begin
      start_q  <= 1'b0;
      rvalid_q <= cra.cra_read;
      rdata_q  <= cra.cra_read ? rd_mux_d : '0;

      if (ctrl_wr) begin
        irq_en_q <= cra.cra_writedata[BIT_IRQ_EN];
      end

      if (arg_err_set) begin
        arg_err_q <= 1'b1;
      end else if (err_clr) begin
        arg_err_q <= 1'b0;
      end

      // Arguments are frozen while the kernel runs.
      if (cra.cra_write && !busy) begin
        for (int k = 0; k < ARG_WORDS; k++) begin
          if (cra.cra_address == ADDR_W'(ARG_BASE + k)) begin
            args_q[k] <= be_merge(args_q[k], cra.cra_writedata, cra.cra_byteenable);
          end
        end
      end

      case (state_q)
        IDLE, DONE: begin
          if (start_req) begin
            state_q  <= RUN;
            start_q  <= 1'b1;
            cycles_q <= '0;
          end else if (state_q == DONE && done_clr) begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          if (cycles_q != '1) begin
            cycles_q <= cycles_q + 1'b1;
          end
          // Completion takes priority over a DONE clear arriving in the same cycle.
          if (kernel_done) begin
            state_q <= DONE;
            runs_q  <= runs_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < ARG_WORDS; gi++) begin : g_args
      assign kernel_args[gi*DATA_W +: DATA_W] = args_q[gi];
    end
  endgenerate

  assign kernel_start          = start_q;
  assign kernel_irq            = (state_q == DONE) && irq_en_q;
  assign cra.cra_readdata      = rdata_q;
  assign cra.cra_readdatavalid = rvalid_q;
  assign cra.cra_waitrequest   = 1'b0;

endmodule
